square_draw_arbiter: RTL and testbench
======================================

Name: square_draw_arbiter

Overview:
- Shares the single VGA adapter pixel port between up to NUM_REQ requesters (player, obstacles, erase/background logic).
- Each requester asks for one SIDE x SIDE square at a base (x,y) in one colour.
- Arbitrates requests round-robin, latches the winner's coordinates and colour, then sequences one pixel per clock onto the VGA port.
- Pulses a per-requester done when its square is complete.
- Sits between game logic and the VGA adapter and replaces ad-hoc per-object plot muxing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SIZE_LOG2, 2, log2 of square side; SIDE = 2**SIZE_LOG2, pixels per square = SIDE*SIDE
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- X_MAX, 160, screen width; used only with the optional feature
- Y_MAX, 120, screen height; used only with the optional feature

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester draw request, level
- req_x  in  NUM_REQ*X_W  packed base x; requester i at [i*X_W +: X_W]
- req_y  in  NUM_REQ*Y_W  packed base y
- req_colour  in  NUM_REQ*3  packed 3-bit colour
- grant  out  NUM_REQ  one-hot; high for the whole draw of the winner
- done  out  NUM_REQ  one-cycle pulse to the winner after its last pixel
- busy  out  1  high whenever state != IDLE
- vga_x  out  X_W  pixel x to adapter
- vga_y  out  Y_W  pixel y to adapter
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write enable

Behaviour:
- Single clock domain. reset_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE
  - grant = 0, done = 0, busy = 0, vga_plot = 0
  - vga_x = 0, vga_y = 0, vga_colour = 0
  - pixel counter = 0
  - round-robin pointer = 0
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - If req != 0, select the winner.
  - The winner is the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - On that edge: latch the winner's x, y and colour; set grant one-hot; clear the counter; go to DRAW.
- DRAW:
  - vga_plot = 1 every cycle.
  - vga_x = base_x + cnt[SIZE_LOG2-1:0].
  - vga_y = base_y + cnt[2*SIZE_LOG2-1:SIZE_LOG2].
  - vga_colour = latched colour.
  - The counter increments by one per cycle, so x varies fastest (raster order).
  - When cnt = SIDE*SIDE-1, go to DONE after that cycle.
- DONE:
  - vga_plot = 0; done[winner] = 1 for exactly one cycle; grant = 0.
  - The pointer becomes winner+1 (mod NUM_REQ).
  - Next state is IDLE.
- Timing:
  - A request seen at edge N gives grant and vga_plot high from cycle N+1 through N+SIDE*SIDE.
  - done is high in cycle N+SIDE*SIDE+1.
  - Back-to-back squares cost SIDE*SIDE+2 cycles each.
- Arithmetic: coordinate sums are truncated to X_W / Y_W bits, i.e. they wrap. No carry out.
- Requester inputs (req, x, y, colour) are ignored while busy. A requester dropping req mid-draw does not abort its draw.
- A requester holding req after done is re-arbitrated. With other requesters pending, it cannot win twice in a row.
- Requests arriving during DRAW/DONE are not lost while held. req is level, with no internal queue.
- Reset asserted mid-draw: the next cycle shows the reset values. No done pulse is issued for the aborted square.
- Only vga_plot qualifies vga_x/vga_y/vga_colour. Their values while vga_plot = 0 are don't-care to the adapter, but must equal the reset values after reset.

Optional Feature:
- Macro: SQUARE_ARB_CLIP_EN
- Defined: during DRAW, vga_plot is forced 0 for any pixel where the full-width (unwrapped) sum has base_x + xoff >= X_MAX or base_y + yoff >= Y_MAX. Cycle count and done timing are unchanged.
- Undefined: no clipping; coordinates wrap as above, and X_MAX/Y_MAX are unused.

Test Plan:
- Single request:
  - Stimulus: req = 4'b0010, x = 10, y = 20, colour = 3'b101.
  - Response: grant = 4'b0010 for 16 cycles; vga_plot high for 16 cycles; pixels (10,20),(11,20)..(13,20),(10,21)..(13,23) in order; done[1] pulses once, 17 cycles after the sampled edge.
- Round-robin:
  - Stimulus: req = 4'b1111 held continuously.
  - Response: grant order 0,1,2,3,0; each grant 16 cycles; consecutive grants separated by exactly 2 cycles (DONE, IDLE).
- Mid-draw input change:
  - Stimulus: during a draw, requester 0 changes x from 5 to 50 and drops req.
  - Response: all 16 pixels use x = 5..8; done[0] still pulses.
- Reset mid-draw:
  - Stimulus: reset_n = 0 at pixel 7.
  - Response: next cycle vga_plot = 0, grant = 0, busy = 0, no done pulse; the next request then starts arbitration from requester 0.
- Wrap, macro undefined:
  - Stimulus: x = 254, y = 126, X_W = 8, Y_W = 7.
  - Response: x sequence 254,255,0,1; y sequence 126,127,0,1.
- Clip, SQUARE_ARB_CLIP_EN defined:
  - Stimulus: x = 158, y = 118.
  - Response: vga_plot high only for the 4 pixels with x in {158,159} and y in {118,119}; done still at cycle +17.

Source files
------------

// File: rtl/square_draw_arbiter_if.sv
// ============================================================================
//  Module      : square_draw_arbiter_if
//  Description : Request/grant bundle between game-logic requesters and the
//                square draw arbiter, plus the arbiter's VGA pixel port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface square_draw_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7
);
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*X_W-1:0] req_x;
    logic [NUM_REQ*Y_W-1:0] req_y;
    logic [NUM_REQ*3-1:0]   req_colour;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     done;
    logic                   busy;
    logic [X_W-1:0]         vga_x;
    logic [Y_W-1:0]         vga_y;
    logic [2:0]             vga_colour;
    logic                   vga_plot;

    // Requester / game-logic side
    modport master (
        output req, req_x, req_y, req_colour,
        input  grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    // Arbiter side
    modport slave (
        input  req, req_x, req_y, req_colour,
        output grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

`default_nettype wire

// File: rtl/square_draw_arbiter.sv
// ============================================================================
//  Module      : square_draw_arbiter
//  Description : Round-robin arbiter that lets several requesters share one
//                VGA pixel port. The winner's SIDE x SIDE square is emitted
//                one pixel per clock in raster order, then done pulses.
//                Optional macro SQUARE_ARB_CLIP_EN suppresses vga_plot for
//                pixels outside X_MAX x Y_MAX (timing is unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module square_draw_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_LOG2 = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int X_MAX     = 160,
    parameter int Y_MAX     = 120
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    square_draw_arbiter_if.slave   bus
);

    localparam int c_ptr_w = $clog2(NUM_REQ);
    localparam int c_cnt_w = 2 * SIZE_LOG2;
    localparam logic [c_cnt_w-1:0] c_cnt_last = '1;

    // Reject configurations the datapath cannot represent
    if (NUM_REQ < 2 || NUM_REQ > 8 || SIZE_LOG2 < 1 || SIZE_LOG2 >= Y_W ||
        X_MAX < 1 || Y_MAX < 1) begin : g_bad_param
        $error("square_draw_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q,      state_d;
    logic [c_cnt_w-1:0]   cnt_q,        cnt_d;
    logic [c_ptr_w-1:0]   ptr_q,        ptr_d;
    logic [c_ptr_w-1:0]   winner_q,     winner_d;
    logic [X_W-1:0]       base_x_q,     base_x_d;
    logic [Y_W-1:0]       base_y_q,     base_y_d;
    logic [2:0]           colour_q,     colour_d;
    logic [NUM_REQ-1:0]   grant_q,      grant_d;
    logic [NUM_REQ-1:0]   done_q,       done_d;
    logic [X_W-1:0]       vga_x_q,      vga_x_d;
    logic [Y_W-1:0]       vga_y_q,      vga_y_d;
    logic [2:0]           vga_colour_q, vga_colour_d;
    logic                 vga_plot_q,   vga_plot_d;

    logic                 w_win_found;
    logic [c_ptr_w-1:0]   w_win_idx;
    logic [c_ptr_w-1:0]   w_cand;
    int                   w_scan;
    logic [X_W-1:0]       w_win_x;
    logic [Y_W-1:0]       w_win_y;
    logic [2:0]           w_win_colour;
    logic [X_W-1:0]       w_base_x;
    logic [Y_W-1:0]       w_base_y;
    logic [c_cnt_w-1:0]   w_pix_cnt;
    logic [X_W-1:0]       w_x_off;
    logic [Y_W-1:0]       w_y_off;
    logic                 w_pix_ok;

    // Round-robin search: first asserted request at or above the pointer, wrapping
    always_comb begin
        w_win_found  = 1'b0;
        w_win_idx    = '0;
        w_scan       = 0;
        w_cand       = '0;
        w_win_x      = '0;
        w_win_y      = '0;
        w_win_colour = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(ptr_q) + k;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            w_cand = c_ptr_w'(w_scan);
            if (!w_win_found && bus.req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (c_ptr_w'(k) == w_win_idx) begin
                w_win_x      = bus.req_x[k*X_W +: X_W];
                w_win_y      = bus.req_y[k*Y_W +: Y_W];
                w_win_colour = bus.req_colour[k*3 +: 3];
            end
        end
    end

    // Address of the pixel that will be shown next cycle; the first pixel
    // comes straight from the request so it appears the cycle after the grant
    always_comb begin
        w_pix_cnt = (state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
        w_base_x  = (state_q == ST_IDLE) ? w_win_x : base_x_q;
        w_base_y  = (state_q == ST_IDLE) ? w_win_y : base_y_q;
        w_x_off   = X_W'(w_pix_cnt[SIZE_LOG2-1:0]);
        w_y_off   = Y_W'(w_pix_cnt[c_cnt_w-1:SIZE_LOG2]);
`ifdef SQUARE_ARB_CLIP_EN
        w_pix_ok  = (({1'b0, w_base_x} + {1'b0, w_x_off}) < (X_W+1)'(X_MAX)) &&
                    (({1'b0, w_base_y} + {1'b0, w_y_off}) < (Y_W+1)'(Y_MAX));
`else
        w_pix_ok  = 1'b1;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        winner_d     = winner_q;
        base_x_d     = base_x_q;
        base_y_d     = base_y_q;
        colour_d     = colour_q;
        grant_d      = grant_q;
        done_d       = '0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_win_found) begin
                    state_d             = ST_DRAW;
                    winner_d            = w_win_idx;
                    base_x_d            = w_win_x;
                    base_y_d            = w_win_y;
                    colour_d            = w_win_colour;
                    grant_d             = '0;
                    grant_d[w_win_idx]  = 1'b1;
                    cnt_d               = w_pix_cnt;
                    vga_x_d             = w_base_x + w_x_off;
                    vga_y_d             = w_base_y + w_y_off;
                    vga_colour_d        = w_win_colour;
                    vga_plot_d          = w_pix_ok;
                end
            end
            ST_DRAW: begin
                if (cnt_q == c_cnt_last) begin
                    state_d          = ST_DONE;
                    grant_d          = '0;
                    done_d[winner_q] = 1'b1;
                    ptr_d            = (winner_q == c_ptr_w'(NUM_REQ - 1)) ?
                                       '0 : winner_q + 1'b1;
                end else begin
                    cnt_d        = w_pix_cnt;
                    vga_x_d      = w_base_x + w_x_off;
                    vga_y_d      = w_base_y + w_y_off;
                    vga_colour_d = colour_q;
                    vga_plot_d   = w_pix_ok;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            winner_q     <= '0;
            base_x_q     <= '0;
            base_y_q     <= '0;
            colour_q     <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            winner_q     <= winner_d;
            base_x_q     <= base_x_d;
            base_y_q     <= base_y_d;
            colour_q     <= colour_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;

endmodule

`default_nettype wire

// File: tb/tb_square_draw_arbiter.sv
// ============================================================================
//  Module      : tb_square_draw_arbiter
//  Description : Randomized bench for square_draw_arbiter with a
//                transaction-level reference model (expected per-cycle
//                output list generated per granted square).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_square_draw_arbiter;

    localparam int N     = 4;
    localparam int SL    = 2;
    localparam int XW    = 8;
    localparam int YW    = 7;
    localparam int XMAX  = 160;
    localparam int YMAX  = 120;
    localparam int SIDE  = 1 << SL;
    localparam int NCYC  = 3000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    square_draw_arbiter_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW)) bus ();

    square_draw_arbiter #(
        .NUM_REQ   (N),
        .SIZE_LOG2 (SL),
        .X_W       (XW),
        .Y_W       (YW),
        .X_MAX     (XMAX),
        .Y_MAX     (YMAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] done;
        logic         plot;
        logic         busy;
        int           x;
        int           y;
        int           col;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rr_ptr = 0;
    bit   chk_rst = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs of one whole square: SIDE*SIDE pixel cycles then the done cycle
    task automatic plan_square();
        int   w;
        int   bx, by, col;
        exp_t e;
        logic [N*XW-1:0] xs;
        logic [N*YW-1:0] ys;
        logic [N*3-1:0]  cs;
        xs = bus.req_x;
        ys = bus.req_y;
        cs = bus.req_colour;
        w  = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && bus.req[(rr_ptr + k) % N]) w = (rr_ptr + k) % N;
        end
        rr_ptr = (w + 1) % N;
        bx  = int'(xs[w*XW +: XW]);
        by  = int'(ys[w*YW +: YW]);
        col = int'(cs[w*3 +: 3]);
        for (int p = 0; p < SIDE*SIDE; p++) begin
            e.grant = '0;
            e.grant[w] = 1'b1;
            e.done  = '0;
            e.busy  = 1'b1;
            e.x     = (bx + p % SIDE) % (1 << XW);
            e.y     = (by + p / SIDE) % (1 << YW);
            e.col   = col;
`ifdef SQUARE_ARB_CLIP_EN
            e.plot  = ((bx + p % SIDE) < XMAX) && ((by + p / SIDE) < YMAX);
`else
            e.plot  = 1'b1;
`endif
            q.push_back(e);
        end
        e.grant = '0;
        e.done  = '0;
        e.done[w] = 1'b1;
        e.plot  = 1'b0;
        e.busy  = 1'b1;
        e.x = 0; e.y = 0; e.col = 0;
        q.push_back(e);
    endtask

    task automatic drive_random();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0)      bus.req = '0;
        else if (sel <= 2) bus.req = '1;
        else               bus.req = N'($urandom);
        for (int i = 0; i < N; i++) begin
            sel = $urandom_range(0, 3);
            bus.req_x[i*XW +: XW] = (sel == 0) ? 8'd254 : (sel == 1) ? 8'd158 : XW'($urandom);
            sel = $urandom_range(0, 3);
            bus.req_y[i*YW +: YW] = (sel == 0) ? 7'd126 : (sel == 1) ? 7'd118 : YW'($urandom);
            bus.req_colour[i*3 +: 3] = 3'($urandom);
        end
        reset_n = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        exp_t e;
        bit   idle;
        bus.req        = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        reset_n        = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("reset_grant",  32'(bus.grant),      32'd0);
        check_eq("reset_done",   32'(bus.done),       32'd0);
        check_eq("reset_busy",   32'(bus.busy),       32'd0);
        check_eq("reset_plot",   32'(bus.vga_plot),   32'd0);
        check_eq("reset_x",      32'(bus.vga_x),      32'd0);
        check_eq("reset_y",      32'(bus.vga_y),      32'd0);
        check_eq("reset_colour", 32'(bus.vga_colour), 32'd0);

        // Directed single request from requester 1, held for one edge only
        reset_n = 1'b1;
        bus.req = 4'b0010;
        bus.req_x[1*XW +: XW]     = 8'd10;
        bus.req_y[1*YW +: YW]     = 7'd20;
        bus.req_colour[1*3 +: 3]  = 3'b101;
        plan_square();

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (q.size() > 0) begin
                e    = q.pop_front();
                idle = 1'b0;
            end else begin
                e.grant = '0; e.done = '0; e.plot = 1'b0; e.busy = 1'b0;
                e.x = 0; e.y = 0; e.col = 0;
                idle = 1'b1;
            end
            check_eq("grant", 32'(bus.grant),    32'(e.grant));
            check_eq("done",  32'(bus.done),     32'(e.done));
            check_eq("plot",  32'(bus.vga_plot), 32'(e.plot));
            check_eq("busy",  32'(bus.busy),     32'(e.busy));
            if (e.plot) begin
                check_eq("vga_x",      32'(bus.vga_x),      32'(e.x));
                check_eq("vga_y",      32'(bus.vga_y),      32'(e.y));
                check_eq("vga_colour", 32'(bus.vga_colour), 32'(e.col));
            end
            if (chk_rst) begin
                check_eq("post_reset_x",      32'(bus.vga_x),      32'd0);
                check_eq("post_reset_y",      32'(bus.vga_y),      32'd0);
                check_eq("post_reset_colour", 32'(bus.vga_colour), 32'd0);
                chk_rst = 1'b0;
            end

            // First few cycles finish the directed square with req dropped
            if (c < 20) begin
                bus.req = '0;
                bus.req_x[1*XW +: XW] = 8'd50;
                reset_n = 1'b1;
            end else begin
                drive_random();
            end

            if (!reset_n) begin
                q.delete();
                rr_ptr  = 0;
                chk_rst = 1'b1;
            end else if (idle && bus.req != '0) begin
                plan_square();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
